counter_run_controller: RTL and testbench

//   Sequencer for the 8-bit T-flip-flop counter datapath (Enable/Clear_b inputs).
//   On Start, it clears the counter, then issues exactly Target single-cycle Enable pulses at a selectable rate.
//   It supports pause/resume and abort, and flags completion.
//   It sits between board switches/keys and the counter; CounterValue goes to the HEX decoders.

---
 rtl/counter_run_controller.sv | 129 ++++++++++++
 tb/tb_counter_run_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_run_controller.sv
// rtl/counter_run_controller.sv - sequencer that clears an 8-bit T-FF counter then issues Target enable pulses
// Rate-divided pulse train with pause/resume/abort; outputs decoded from state plus the divider tick.
module counter_run_controller #(
    parameter int DIV_W = 26,
    parameter int RATE1 = 4,
    parameter int RATE2 = 16,
    parameter int RATE3 = 50000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic [1:0] RateSel,
    input  logic [7:0] Target,
    output logic       Enable,
    output logic       Clear_b,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       issued;
    logic [7:0]       issued_next;
    logic [7:0]       target_q;
    logic [7:0]       target_next;
    logic [1:0]       rate_q;
    logic [1:0]       rate_next;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W-1:0] reload;
    logic             tick;
    logic             start_req;
    logic             last_pulse;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            issued   <= 8'd0;
            target_q <= 8'd0;
            rate_q   <= 2'd0;
            div_cnt  <= '0;
        end else begin
            state    <= state_next;
            issued   <= issued_next;
            target_q <= target_next;
            rate_q   <= rate_next;
            div_cnt  <= div_next;
        end
    end

    // Divider reload is period-1 so a tick lands every N RUN clocks.
    always_comb begin
        reload = '0;
        case (rate_q)
            2'b01:   reload = DIV_W'(RATE1 - 1);
            2'b10:   reload = DIV_W'(RATE2 - 1);
            2'b11:   reload = DIV_W'(RATE3 - 1);
            default: reload = '0;
        endcase
    end

    assign tick       = (state == ST_RUN) && (div_cnt == '0);
    assign start_req  = Start && !Stop;
    assign last_pulse = (issued == (target_q - 8'd1));

    always_comb begin
        state_next  = state;
        issued_next = issued;
        target_next = target_q;
        rate_next   = rate_q;
        div_next    = div_cnt;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_req) begin
                    state_next  = ST_CLEAR;
                    rate_next   = RateSel;
                    target_next = Target;
                    issued_next = 8'd0;
                end else if (Stop && (state == ST_DONE)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                div_next   = '0;
                state_next = (target_q == 8'd0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                // A tick coinciding with Stop still counts; completion beats pausing.
                if (tick) begin
                    issued_next = issued + 8'd1;
                    div_next    = reload;
                    if (last_pulse) begin
                        state_next = ST_DONE;
                    end else if (Stop) begin
                        state_next = ST_PAUSE;
                    end
                end else begin
                    div_next = div_cnt - DIV_W'(1);
                    if (Stop) begin
                        state_next = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (Stop) begin
                    state_next = ST_IDLE;
                end else if (Start) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign Enable  = tick;
    assign Clear_b = (state != ST_CLEAR);
    assign Busy    = (state == ST_CLEAR) || (state == ST_RUN) || (state == ST_PAUSE);
    assign Done    = (state == ST_DONE);

endmodule

// File: tb/tb_counter_run_controller.sv
// tb/tb_counter_run_controller.sv - vector table, directed sequences and random run checks for counter_run_controller
module tb_counter_run_controller;

    localparam int R1 = 4;
    localparam int R2 = 16;
    localparam int R3 = 9;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Stop = 1'b0;
    logic [1:0] RateSel = 2'd0;
    logic [7:0] Target = 8'd0;
    logic       Enable;
    logic       Clear_b;
    logic       Busy;
    logic       Done;

    counter_run_controller #(.DIV_W(26), .RATE1(R1), .RATE2(R2), .RATE3(R3)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop),
        .RateSel(RateSel), .Target(Target),
        .Enable(Enable), .Clear_b(Clear_b), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail = 0;

    // Reference: run progress is the number of RUN clocks elapsed since the clear.
    localparam int P_IDLE = 0, P_CLEAR = 1, P_RUN = 2, P_PAUSE = 3, P_DONE = 4;
    int m_phase = P_IDLE;
    int m_k = 0;
    int m_n = 1;
    int m_tgt = 0;

    logic [1:0] drv_rs = 2'd0;
    logic [7:0] drv_tg = 8'd0;
    int  hw_count = 0;
    logic prev_done = 1'b0;

    typedef struct {
        logic st, sp, rst;
        logic [1:0] rs;
        logic [7:0] tg;
        logic en, clb, busy, done;
    } vec_t;
    vec_t tbl[$];

    function automatic int period(input logic [1:0] rs);
        case (rs)
            2'd1:    return R1;
            2'd2:    return R2;
            2'd3:    return R3;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic st, input logic sp, input logic rst,
                              input logic [1:0] rs, input logic [7:0] tg);
        if (rst) begin
            m_phase = P_IDLE;
            m_k = 0;
            m_tgt = 0;
            m_n = 1;
        end else begin
            case (m_phase)
                P_IDLE, P_DONE: begin
                    if (st && !sp) begin
                        m_phase = P_CLEAR;
                        m_tgt = tg;
                        m_n = period(rs);
                    end else if (sp && m_phase == P_DONE) begin
                        m_phase = P_IDLE;
                    end
                end
                P_CLEAR: begin
                    m_k = 0;
                    m_phase = (m_tgt == 0) ? P_DONE : P_RUN;
                end
                P_RUN: begin
                    if ((m_k % m_n) == 0 && (m_k / m_n + 1) == m_tgt) m_phase = P_DONE;
                    else if (sp) m_phase = P_PAUSE;
                    m_k++;
                end
                default: begin
                    if (sp) m_phase = P_IDLE;
                    else if (st) m_phase = P_RUN;
                end
            endcase
        end
    endtask

    task automatic cycle(input logic st, input logic sp, input logic rst);
        Start = st; Stop = sp; Reset = rst; RateSel = drv_rs; Target = drv_tg;
        @(posedge Clock);
        model_step(st, sp, rst, drv_rs, drv_tg);
        @(negedge Clock);
        chk("enable", Enable, (m_phase == P_RUN) && ((m_k % m_n) == 0));
        chk("clear_b", Clear_b, m_phase != P_CLEAR);
        chk("busy", Busy, m_phase == P_CLEAR || m_phase == P_RUN || m_phase == P_PAUSE);
        chk("done", Done, m_phase == P_DONE);
        if (!Clear_b) hw_count = 0;
        else if (Enable) hw_count++;
        if (Done && !prev_done) chk("count_at_done", hw_count, m_tgt);
        prev_done = Done;
    endtask

    function automatic void add(input logic st, input logic sp, input logic rst,
                                input logic [1:0] rs, input logic [7:0] tg,
                                input logic en, input logic clb, input logic busy, input logic done);
        vec_t v;
        v.st = st; v.sp = sp; v.rst = rst; v.rs = rs; v.tg = tg;
        v.en = en; v.clb = clb; v.busy = busy; v.done = done;
        tbl.push_back(v);
    endfunction

    task automatic run_to_done(input int limit, output int pulses);
        pulses = 0;
        for (int j = 0; j < limit && !Done; j++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (Enable) pulses++;
        end
        chk("done_reached", Done, 1'b1);
    endtask

    initial begin
        int pulses;
        int pos[$];
        int done_at;

        add(0,0,1,0,0, 0,1,0,0);
        add(0,0,1,0,0, 0,1,0,0);
        for (int i = 0; i < 5; i++) add(0,0,0,0,0, 0,1,0,0);
        add(1,0,0,0,5, 0,0,1,0);
        for (int i = 0; i < 5; i++) add(0,0,0,0,5, 1,1,1,0);
        add(0,0,0,0,5, 0,1,0,1);
        add(0,1,0,0,5, 0,1,0,0);
        add(1,0,0,0,0, 0,0,1,0);
        add(0,0,0,0,0, 0,1,0,1);
        add(0,1,0,0,0, 0,1,0,0);
        add(1,1,0,0,7, 0,1,0,0);
        add(0,0,0,0,7, 0,1,0,0);

        foreach (tbl[i]) begin
            drv_rs = tbl[i].rs;
            drv_tg = tbl[i].tg;
            cycle(tbl[i].st, tbl[i].sp, tbl[i].rst);
            chk("tbl_enable", Enable, tbl[i].en);
            chk("tbl_clear_b", Clear_b, tbl[i].clb);
            chk("tbl_busy", Busy, tbl[i].busy);
            chk("tbl_done", Done, tbl[i].done);
        end

        // RATE1 spacing: pulses on RUN clocks 0, 4, 8
        drv_rs = 2'd1; drv_tg = 8'd3;
        cycle(1, 0, 0);
        done_at = -1;
        for (int j = 0; j < 30 && done_at < 0; j++) begin
            cycle(0, 0, 0);
            if (Enable) pos.push_back(j);
            if (Done) done_at = j;
        end
        chk("rate1_pulse_count", pos.size(), 3);
        if (pos.size() == 3) begin
            chk("rate1_pos0", pos[0], 0);
            chk("rate1_pos1", pos[1], 4);
            chk("rate1_pos2", pos[2], 8);
        end
        chk("rate1_done_clock", done_at, 9);
        chk("rate1_counter", hw_count, 3);
        cycle(0, 1, 0);

        // Pause after three pulses, hold, resume
        drv_rs = 2'd0; drv_tg = 8'd10;
        cycle(1, 0, 0);
        for (int j = 0; j < 3; j++) cycle(0, 0, 0);
        cycle(0, 1, 0);
        chk("pause_entered_busy", Busy, 1'b1);
        chk("pause_count", hw_count, 3);
        for (int j = 0; j < 10; j++) begin
            cycle(0, 0, 0);
            chk("pause_no_enable", Enable, 1'b0);
            chk("pause_clear_b", Clear_b, 1'b1);
        end
        drv_rs = 2'd3; drv_tg = 8'd2;
        cycle(1, 0, 0);
        pulses = Enable ? 1 : 0;
        begin
            int more;
            run_to_done(40, more);
            pulses += more;
        end
        chk("resume_pulses", pulses, 7);
        chk("resume_counter", hw_count, 10);
        cycle(0, 1, 0);

        // Reset in the middle of a run
        drv_rs = 2'd0; drv_tg = 8'd8;
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        chk("rst_enable", Enable, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_clear_b", Clear_b, 1'b1);
        cycle(0, 0, 0);
        chk("rst_no_pulse", Enable, 1'b0);
        drv_tg = 8'd3;
        cycle(1, 0, 0);
        chk("fresh_clear_low", Clear_b, 1'b0);
        chk("fresh_counter_zero", hw_count, 0);
        run_to_done(20, pulses);
        chk("fresh_pulses", pulses, 3);

        // Maximum target terminates at 255 without wrapping
        drv_tg = 8'd255;
        cycle(1, 0, 0);
        run_to_done(300, pulses);
        chk("max_pulses", pulses, 255);
        cycle(0, 1, 0);

        // Random stimulus against the reference
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                drv_rs = 2'($urandom_range(0, 3));
                drv_tg = 8'($urandom_range(0, 12));
            end
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
